// File: rtl/time_counter_if.sv
// Control/status bundle between the time_counter and its user (buttons, display decoders).
// TIME_COUNTER_ALARM_EN adds the alarm compare inputs and the alarm_hit pulse.
interface time_counter_if;
  logic       run;
  logic       set_en;
  logic [1:0] set_field;
  logic       set_up;
  logic       set_down;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [5:0] hours;
  logic       sec_tick;
  logic [1:0] mode;
`ifdef TIME_COUNTER_ALARM_EN
  logic [5:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_arm;
  logic       alarm_hit;

  modport master (
    output run, set_en, set_field, set_up, set_down, alarm_hours, alarm_minutes, alarm_arm,
    input  seconds, minutes, hours, sec_tick, mode, alarm_hit
  );
  modport slave (
    input  run, set_en, set_field, set_up, set_down, alarm_hours, alarm_minutes, alarm_arm,
    output seconds, minutes, hours, sec_tick, mode, alarm_hit
  );
`else
  modport master (
    output run, set_en, set_field, set_up, set_down,
    input  seconds, minutes, hours, sec_tick, mode
  );
  modport slave (
    input  run, set_en, set_field, set_up, set_down,
    output seconds, minutes, hours, sec_tick, mode
  );
`endif
endinterface

// File: rtl/time_counter.sv
// Time-of-day counter: 1 Hz prescaler, hh:mm:ss in binary, run/stop/set FSM with field edits.
// Optional alarm compare enabled by defining TIME_COUNTER_ALARM_EN.
module time_counter #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned CNT_W    = 27
) (
  input logic           clk,
  input logic           reset,
  time_counter_if.slave bus
);
  typedef enum logic [1:0] {
    StStop = 2'b00,
    StRun  = 2'b01,
    StSet  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] PrescMax = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic             tick_q, tick_d;

  // Single-field step with independent wrap at max_v; no carry out.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop:  state_d = bus.set_en ? StSet : (bus.run ? StRun : StStop);
      StRun:   state_d = bus.set_en ? StSet : (bus.run ? StRun : StStop);
      StSet:   state_d = bus.set_en ? StSet : StStop;
      default: state_d = StStop;
    endcase
  end

  // Prescaler only runs while staying in RUN, so a tick on the exit cycle is dropped.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (state_q == StRun && state_d == StRun) begin
      if (presc_q == PrescMax) tick_d = 1'b1;
      else                     presc_d = presc_q + 1'b1;
    end
  end

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (tick_d) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hr_d  = (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (state_q == StSet && (bus.set_up ^ bus.set_down)) begin
      unique case (bus.set_field)
        2'b00:   sec_d = wrap_step(sec_q, 6'd59, bus.set_up);
        2'b01:   min_d = wrap_step(min_q, 6'd59, bus.set_up);
        2'b10:   hr_d  = wrap_step(hr_q, 6'd23, bus.set_up);
        default: ;
      endcase
    end
  end

`ifdef TIME_COUNTER_ALARM_EN
  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = tick_d && bus.alarm_arm && (hr_d == bus.alarm_hours) &&
              (min_d == bus.alarm_minutes) && (sec_d == 6'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) alarm_q <= 1'b0;
    else       alarm_q <= alarm_d;
  end

  assign bus.alarm_hit = alarm_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StStop;
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hr_q    <= 6'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.seconds  = sec_q;
  assign bus.minutes  = min_q;
  assign bus.hours    = hr_q;
  assign bus.sec_tick = tick_q;
  assign bus.mode     = state_q;
endmodule

// File: tb/tb_time_counter.sv
// Randomized bench for time_counter: time-of-day model checked every cycle plus directed literals.
// Covers the alarm port when TIME_COUNTER_ALARM_EN is defined.
module tb_time_counter;
  localparam int unsigned TickDiv = 4;
  localparam int          Day     = 86400;

  logic clk = 1'b0;
  logic reset;
  time_counter_if tc_if ();

  time_counter #(.TICK_DIV(TickDiv), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tc_if.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode code, cycles spent in RUN since last tick, time of day in seconds.
  int m_mode, m_cnt, m_tod, nmode, h, m, s;
  bit m_tick, m_alarm, chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_tod = 0; m_tick = 0; m_alarm = 0; chk_en = 1'b1;
    end else begin
      if (tc_if.set_en)                  nmode = 2;
      else if (m_mode == 2 || !tc_if.run) nmode = 0;
      else                                nmode = 1;
      m_tick = 0;
      m_alarm = 0;
      if (m_mode == 1 && nmode == 1) begin
        m_cnt++;
        if (m_cnt == TickDiv) begin
          m_cnt = 0;
          m_tick = 1;
          m_tod = (m_tod + 1) % Day;
`ifdef TIME_COUNTER_ALARM_EN
          m_alarm = tc_if.alarm_arm && (m_tod / 3600 == int'(tc_if.alarm_hours)) &&
                    ((m_tod / 60) % 60 == int'(tc_if.alarm_minutes)) && (m_tod % 60 == 0);
`endif
        end
      end else begin
        m_cnt = 0;
      end
      if (m_mode == 2 && (tc_if.set_up != tc_if.set_down) && tc_if.set_field != 2'b11) begin
        h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
        case (tc_if.set_field)
          2'b00:   s = (s + (tc_if.set_up ? 1 : 59)) % 60;
          2'b01:   m = (m + (tc_if.set_up ? 1 : 59)) % 60;
          default: h = (h + (tc_if.set_up ? 1 : 23)) % 24;
        endcase
        m_tod = h * 3600 + m * 60 + s;
      end
      m_mode = nmode;
    end
    #1;
    if (chk_en) begin
      chk("mode", int'(tc_if.mode), m_mode);
      chk("seconds", int'(tc_if.seconds), m_tod % 60);
      chk("minutes", int'(tc_if.minutes), (m_tod / 60) % 60);
      chk("hours", int'(tc_if.hours), m_tod / 3600);
      chk("sec_tick", int'(tc_if.sec_tick), int'(m_tick));
`ifdef TIME_COUNTER_ALARM_EN
      chk("alarm_hit", int'(tc_if.alarm_hit), int'(m_alarm));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic up, input logic down);
    tc_if.set_up = up; tc_if.set_down = down;
    cyc(1);
    tc_if.set_up = 1'b0; tc_if.set_down = 1'b0;
  endtask

  task automatic chk_time(input string name, input int hh, input int mm, input int ss);
    chk({name, "_h"}, int'(tc_if.hours), hh);
    chk({name, "_m"}, int'(tc_if.minutes), mm);
    chk({name, "_s"}, int'(tc_if.seconds), ss);
  endtask

`ifdef TIME_COUNTER_ALARM_EN
  task automatic alarm_run(input logic arm, input int exp_hits);
    int hits;
    hits = 0;
    reset = 1'b1; cyc(1); reset = 1'b0;
    tc_if.set_en = 1'b1; cyc(1);
    tc_if.set_field = 2'b00;
    pulse(1'b0, 1'b1); pulse(1'b0, 1'b1);
    tc_if.alarm_hours = 6'd0; tc_if.alarm_minutes = 6'd1; tc_if.alarm_arm = arm;
    tc_if.set_en = 1'b0; cyc(1);
    tc_if.run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (tc_if.alarm_hit) begin
        hits++;
        chk_time("alarm_at", 0, 1, 0);
      end
    end
    chk(arm ? "alarm_armed_hits" : "alarm_disarmed_hits", hits, exp_hits);
    tc_if.run = 1'b0;
  endtask
`endif

  initial begin
    int ticks;
    reset = 1'b1;
    tc_if.run = 1'b0; tc_if.set_en = 1'b0; tc_if.set_field = 2'b00;
    tc_if.set_up = 1'b0; tc_if.set_down = 1'b0;
`ifdef TIME_COUNTER_ALARM_EN
    tc_if.alarm_hours = 6'd0; tc_if.alarm_minutes = 6'd0; tc_if.alarm_arm = 1'b0;
`endif
    cyc(1);
    reset = 1'b0;
    chk_time("reset", 0, 0, 0);
    chk("reset_mode", int'(tc_if.mode), 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      ticks += int'(tc_if.sec_tick);
    end
    chk("idle_ticks", ticks, 0);
    chk_time("idle", 0, 0, 0);

    // Counting from reset
    reset = 1'b1; cyc(1);
    reset = 1'b0; tc_if.run = 1'b1;
    cyc(1);
    chk("run_mode", int'(tc_if.mode), 1);
    cyc(3);
    chk("pre_tick_s", int'(tc_if.seconds), 0);
    cyc(1);
    chk("first_tick_s", int'(tc_if.seconds), 1);
    chk("first_tick_pulse", int'(tc_if.sec_tick), 1);
    cyc(16);
    chk("run20_s", int'(tc_if.seconds), 5);

    // Load 23:59:58 in SET, exercising wraps and ignored edits
    tc_if.set_en = 1'b1; cyc(1);
    chk("set_mode", int'(tc_if.mode), 2);
    tc_if.set_field = 2'b10; pulse(1'b0, 1'b1);
    chk("hours_wrap_down", int'(tc_if.hours), 23);
    tc_if.set_field = 2'b01; pulse(1'b0, 1'b1);
    tc_if.set_field = 2'b00;
    repeat (7) pulse(1'b0, 1'b1);
    chk_time("loaded", 23, 59, 58);
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0);
    chk_time("sec_wrap_up", 23, 59, 0);
    pulse(1'b0, 1'b1); pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    chk_time("both_pulses", 23, 59, 58);
    tc_if.set_field = 2'b11; pulse(1'b1, 1'b0);
    chk_time("field_none", 23, 59, 58);
    chk("run_in_set_mode", int'(tc_if.mode), 2);
    tc_if.set_en = 1'b0; tc_if.run = 1'b0; cyc(1);
    chk("exit_set_mode", int'(tc_if.mode), 0);

    // Full rollover
    tc_if.run = 1'b1; cyc(1);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      ticks += int'(tc_if.sec_tick);
    end
    chk("rollover_ticks", ticks, 2);
    chk_time("rollover", 0, 0, 0);

    // set_en arrives on the wrap cycle: tick dropped
    cyc(3);
    tc_if.set_en = 1'b1; cyc(1);
    chk("race_mode", int'(tc_if.mode), 2);
    chk("race_s", int'(tc_if.seconds), 0);
    chk("race_tick", int'(tc_if.sec_tick), 0);

    // Reset while editing
    tc_if.set_field = 2'b00; tc_if.set_up = 1'b1; reset = 1'b1; cyc(1);
    chk_time("reset_in_set", 0, 0, 0);
    chk("reset_in_set_mode", int'(tc_if.mode), 0);
    reset = 1'b0; tc_if.set_up = 1'b0; tc_if.set_en = 1'b0; tc_if.run = 1'b0;

`ifdef TIME_COUNTER_ALARM_EN
    alarm_run(1'b1, 1);
    alarm_run(1'b0, 0);
`endif

    // Random phase, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) tc_if.set_en = ~tc_if.set_en;
      if ($urandom_range(0, 19) == 0) tc_if.run = ~tc_if.run;
      tc_if.set_field = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0, 1:    begin tc_if.set_up = 1'b1; tc_if.set_down = 1'b0; end
        2, 3:    begin tc_if.set_up = 1'b0; tc_if.set_down = 1'b1; end
        4:       begin tc_if.set_up = 1'b1; tc_if.set_down = 1'b1; end
        default: begin tc_if.set_up = 1'b0; tc_if.set_down = 1'b0; end
      endcase
`ifdef TIME_COUNTER_ALARM_EN
      tc_if.alarm_hours = 6'($urandom_range(0, 1));
      tc_if.alarm_minutes = 6'($urandom_range(0, 2));
      tc_if.alarm_arm = 1'($urandom_range(0, 1));
`endif
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
